// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Serial receive bundle: the incoming line plus the received
//                word, its completion pulse, error flags and busy status.
//                master modport = line driver / result consumer
//                slave  modport = receiver
//  Ports       : rx (line, idle 1), rx_data[DATA_BITS], valid, parity_err,
//                frame_err, busy
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx,
        input  rx_data, valid, parity_err, frame_err, busy
    );

    modport slave (
        input  rx,
        output rx_data, valid, parity_err, frame_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver. The line is synchronised through two flops,
//                a start edge is detected from IDLE and every bit is sampled
//                once, at mid-bit, using a counter restarted at each sample.
//                Frames with parity or stop-bit errors are still reported.
//  Ports       : clk          - clock, rising edge
//                rst          - synchronous active-high reset
//                bus (slave)  - rx in; rx_data, valid, parity_err,
//                               frame_err, busy out
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int    DATA_BITS    = 8,
    parameter string PARITY_BIT   = "none",
    parameter int    STOP_BITS    = 1,
    parameter int    UART_CLK_DIV = 10
) (
    input  wire logic clk,
    input  wire logic rst,
    uart_rx_if.slave  bus
);

    localparam int c_CNT_W = $clog2(UART_CLK_DIV);
    localparam int c_BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [c_CNT_W-1:0] c_HALF      = c_CNT_W'(UART_CLK_DIV / 2);
    localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(UART_CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_DATA = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_STOP = c_BIT_W'(STOP_BITS - 1);
    localparam bit                 c_HAS_PAR   = (PARITY_BIT != "none");
    localparam bit                 c_ODD       = (PARITY_BIT == "odd");

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t                 state_q;
    logic                   sync1_q;
    logic                   sync2_q;      // rx_s: synchronised line
    logic [c_CNT_W-1:0]     cnt_q;        // cycles since T0 / last sample
    logic [c_BIT_W-1:0]     bit_q;        // data or stop bit index
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;        // running XOR of data (+ parity) samples
    logic                   ferr_acc_q;   // a non-final stop bit was 0
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   valid_q;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   busy_q;

    // The start bit is sampled half a bit after T0; every later bit one
    // full bit after the previous sample (counter restarts at each sample).
    logic w_tick;
    assign w_tick = (state_q == START) ? (cnt_q == c_HALF) : (cnt_q == c_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            ferr_acc_q <= 1'b0;
            rx_data_q  <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q <= bus.rx;
            sync2_q <= sync1_q;
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + c_CNT_W'(1);

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (!sync2_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (w_tick) begin
                        cnt_q <= '0;
                        if (sync2_q) begin
                            // Line was high again at mid-bit: false start.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= DATA;
                            par_q      <= 1'b0;
                            ferr_acc_q <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    if (w_tick) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
                        par_q   <= par_q ^ sync2_q;
                        if (bit_q == c_LAST_DATA) begin
                            bit_q   <= '0;
                            state_q <= c_HAS_PAR ? PARITY : STOP;
                        end else begin
                            bit_q <= bit_q + c_BIT_W'(1);
                        end
                    end
                end

                PARITY: begin
                    if (w_tick) begin
                        cnt_q   <= '0;
                        par_q   <= par_q ^ sync2_q;
                        state_q <= STOP;
                    end
                end

                STOP: begin
                    if (w_tick) begin
                        cnt_q <= '0;
                        if (bit_q == c_LAST_STOP) begin
                            bit_q     <= '0;
                            valid_q   <= 1'b1;
                            rx_data_q <= shift_q;
                            ferr_q    <= ferr_acc_q | ~sync2_q;
                            // par_q holds XOR(data, parity): 0 is good for
                            // even, 1 is good for odd.
                            perr_q    <= c_HAS_PAR & (par_q ^ c_ODD);
                            // A line still low here is a break: hold off
                            // until it returns high so no phantom frames start.
                            state_q   <= sync2_q ? IDLE : WAIT_HIGH;
                            busy_q    <= ~sync2_q;
                        end else begin
                            bit_q      <= bit_q + c_BIT_W'(1);
                            ferr_acc_q <= ferr_acc_q | ~sync2_q;
                        end
                    end
                end

                WAIT_HIGH: begin
                    cnt_q <= '0;
                    if (sync2_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Bench for uart_rx. Two receivers: 8N1 at 10 clk/bit and
//                8E2 at 7 clk/bit. Each transmitted frame predicts its own
//                result (cycle of valid, word, flags) from the frame bits and
//                timing rules; a per-cycle compare process checks valid and
//                the held outputs against those predictions.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_if #(.DATA_BITS(8)) bus1 ();

    uart_rx #(
        .DATA_BITS(8), .PARITY_BIT("none"), .STOP_BITS(1), .UART_CLK_DIV(10)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    uart_rx #(
        .DATA_BITS(8), .PARITY_BIT("even"), .STOP_BITS(2), .UART_CLK_DIV(7)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        int         cyc;
        logic [7:0] data;
        bit         perr;
        bit         ferr;
    } exp_t;

    exp_t q [2][$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   rst_q = 1'b1;

    logic [1:0] dv, dp, df, db;
    logic [7:0] dd [2];
    logic [7:0] ld [2];
    bit   [1:0] lp, lf;
    int         vcount [2];
    int         vcyc [2];
    bit         ev;

    assign dv = {bus1.valid,      bus0.valid};
    assign dp = {bus1.parity_err, bus0.parity_err};
    assign df = {bus1.frame_err,  bus0.frame_err};
    assign db = {bus1.busy,       bus0.busy};
    always_comb begin
        dd[0] = bus0.rx_data;
        dd[1] = bus1.rx_data;
    end

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string nm, input int d, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, d, cyc, act, exp);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            ld[d] = '0; vcount[d] = 0; vcyc[d] = 0;
        end
        lp = '0; lf = '0;
    end

    // Per-cycle compare against the predicted frame results.
    always @(negedge clk) begin
        if (rst_q) begin
            for (int d = 0; d < 2; d++) begin
                q[d].delete();
                ld[d] = '0;
            end
            lp = '0;
            lf = '0;
        end
        for (int d = 0; d < 2; d++) begin
            ev = 1'b0;
            if (!rst_q) begin
                while (q[d].size() > 0 && q[d][0].cyc < cyc) begin
                    chk("missed_valid", d, 0, 1);
                    void'(q[d].pop_front());
                end
                if (q[d].size() > 0 && q[d][0].cyc == cyc) begin
                    ev    = 1'b1;
                    ld[d] = q[d][0].data;
                    lp[d] = q[d][0].perr;
                    lf[d] = q[d][0].ferr;
                    void'(q[d].pop_front());
                end
            end else begin
                chk("busy_in_reset", d, int'(db[d]), 0);
            end
            chk("valid",      d, int'(dv[d]), int'(ev));
            chk("rx_data",    d, int'(dd[d]), int'(ld[d]));
            chk("parity_err", d, int'(dp[d]), int'(lp[d]));
            chk("frame_err",  d, int'(df[d]), int'(lf[d]));
            if (dv[d]) begin
                vcount[d]++;
                vcyc[d] = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int d, input logic b);
        if (d == 0) bus0.rx = b;
        else        bus1.rx = b;
    endtask

    // Drive one frame starting in the current cycle n. The line falls in n,
    // rx_s falls in n+2, T0 = n+3; the last sample falls at
    // T0 + div/2 + div*(bits-1) and valid follows one cycle later.
    task automatic send_frame(input int d, input logic [7:0] data,
                              input bit bad_par, input bit [1:0] stops);
        bit   bits[$];
        int   n, nb, div, nstop;
        bit   fe;
        exp_t e;
        div   = (d == 0) ? 10 : 7;
        nstop = (d == 0) ? 1 : 2;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (d == 1) bits.push_back((^data) ^ bad_par);
        fe = 1'b0;
        for (int k = 0; k < nstop; k++) begin
            bits.push_back(stops[k]);
            if (!stops[k]) fe = 1'b1;
        end
        nb     = bits.size();
        n      = cyc;
        e.cyc  = n + 3 + div / 2 + div * (nb - 1) + 1;
        e.data = data;
        e.perr = (d == 1) && bad_par;
        e.ferr = fe;
        q[d].push_back(e);
        for (int i = 0; i < nb; i++) begin
            set_rx(d, bits[i]);
            repeat (div) tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        int         n, h, vc, gap;
        logic [7:0] rd;
        bit   [1:0] st;

        bus0.rx = 1'b1;
        bus1.rx = 1'b1;
        rst     = 1'b1;
        repeat (4) tick();
        chk("reset_rx_data", 0, int'(bus0.rx_data), 0);
        chk("reset_valid",   1, int'(bus1.valid), 0);
        chk("reset_busy",    0, int'(bus0.busy), 0);
        rst = 1'b0;
        repeat (3) tick();

        // 8N1 frame 0xA5: valid at T0+96 = n+99.
        n = cyc;
        send_frame(0, 8'hA5, 1'b0, 2'b11);
        repeat (5) tick();
        chk("a5_latency",    0, vcyc[0] - n, 99);
        chk("a5_count",      0, vcount[0], 1);
        chk("a5_data",       0, int'(bus0.rx_data), 8'hA5);
        chk("a5_frame_err",  0, int'(bus0.frame_err), 0);
        chk("a5_parity_err", 0, int'(bus0.parity_err), 0);

        // 3-cycle glitch: false start, busy back to 0 by T0+6.
        n = cyc;
        set_rx(0, 1'b0);
        repeat (3) tick();
        set_rx(0, 1'b1);
        repeat (2) tick();
        chk("glitch_busy_hi", 0, int'(bus0.busy), 1);
        repeat (4) tick();
        chk("glitch_busy_lo", 0, int'(bus0.busy), 0);
        repeat (20) tick();
        chk("glitch_no_valid", 0, vcount[0], 1);

        // Even parity, 0x03 with parity bit 1 (wrong), then 0 (right).
        n = cyc;
        send_frame(1, 8'h03, 1'b1, 2'b11);
        repeat (5) tick();
        chk("e03_latency", 1, vcyc[1] - n, 84);
        chk("e03_data",    1, int'(bus1.rx_data), 8'h03);
        chk("e03_perr1",   1, int'(bus1.parity_err), 1);
        send_frame(1, 8'h03, 1'b0, 2'b11);
        repeat (5) tick();
        chk("e03_perr0",   1, int'(bus1.parity_err), 0);

        // Break: stop bit 0 and line held low for 50 bit times.
        vc = vcount[0];
        send_frame(0, 8'h5A, 1'b0, 2'b00);
        for (int k = 0; k < 5; k++) begin
            repeat (100) tick();
            chk("break_busy_hi", 0, int'(bus0.busy), 1);
        end
        chk("break_one_valid", 0, vcount[0] - vc, 1);
        chk("break_frame_err", 0, int'(bus0.frame_err), 1);
        chk("break_data",      0, int'(bus0.rx_data), 8'h5A);
        set_rx(0, 1'b1);
        h = cyc;
        repeat (4) tick();
        chk("break_busy_lo", 0, int'(bus0.busy), 0);
        chk("break_release", 0, cyc - h, 4);
        repeat (10) tick();

        // Reset during data bit 4, then a clean 0x3C.
        rd = 8'h96;
        vc = vcount[0];
        set_rx(0, 1'b0);
        repeat (10) tick();
        for (int i = 0; i < 4; i++) begin
            set_rx(0, rd[i]);
            repeat (10) tick();
        end
        set_rx(0, rd[4]);
        repeat (5) tick();
        rst = 1'b1;
        set_rx(0, 1'b1);
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_no_valid", 0, vcount[0] - vc, 0);
        chk("rst_data0",    0, int'(bus0.rx_data), 0);
        chk("rst_ferr0",    0, int'(bus0.frame_err), 0);
        chk("rst_data1",    1, int'(bus1.rx_data), 0);
        chk("rst_perr1",    1, int'(bus1.parity_err), 0);
        chk("rst_busy0",    0, int'(bus0.busy), 0);
        send_frame(0, 8'h3C, 1'b0, 2'b11);
        repeat (5) tick();
        chk("post_rst_data",  0, int'(bus0.rx_data), 8'h3C);
        chk("post_rst_count", 0, vcount[0] - vc, 1);

        // 256 random bytes back-to-back, 8N1.
        vc = vcount[0];
        for (int i = 0; i < 256; i++)
            send_frame(0, 8'($urandom), 1'b0, 2'b11);
        repeat (5) tick();
        chk("loop_count", 0, vcount[0] - vc, 256);

        // Random 8E2 frames with occasional parity and stop-bit errors.
        for (int i = 0; i < 40; i++) begin
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            send_frame(1, 8'($urandom), ($urandom_range(0, 3) == 0), st);
            set_rx(1, 1'b1);
            gap = st[1] ? $urandom_range(0, 10) : $urandom_range(2, 10);
            repeat (gap) tick();
        end

        repeat (20) tick();
        chk("pending0", 0, q[0].size(), 0);
        chk("pending1", 1, q[1].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
